// File: rtl/ppu_apu_resp_buffer_if.sv
// ============================================================================
// ppu_apu_resp_buffer_if
// Handshake and result signals between the CV32E40P APU master port, the
// response buffer and the posit unit's APU wrapper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ppu_apu_resp_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5
);
  // Core side
  logic                  core_req_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic                  core_rready_i;
  logic [DATA_WIDTH-1:0] core_rdata_o;
  logic [FLAG_WIDTH-1:0] core_rflags_o;
  // Unit side
  logic                  unit_req_o;
  logic                  unit_gnt_i;
  logic                  unit_rvalid_i;
  logic [DATA_WIDTH-1:0] unit_rdata_i;
  logic [FLAG_WIDTH-1:0] unit_rflags_i;

  // The buffer itself
  modport slave (
    input  core_req_i, core_rready_i,
    input  unit_gnt_i, unit_rvalid_i, unit_rdata_i, unit_rflags_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
    output unit_req_o
  );

  // Whatever plays core and unit around the buffer
  modport master (
    output core_req_i, core_rready_i,
    output unit_gnt_i, unit_rvalid_i, unit_rdata_i, unit_rflags_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_rflags_o,
    input  unit_req_o
  );
endinterface

`default_nettype wire

// File: rtl/ppu_apu_resp_buffer.sv
// ============================================================================
// ppu_apu_resp_buffer
// Credit gate and result FIFO between the CV32E40P APU port and the posit
// unit. Requests are issued only while a result slot is guaranteed, so the
// unit's non-stallable result channel never loses data; results are handed
// to the core under a valid/ready handshake.
// Optional feature: define PPU_RESP_BYPASS_EN for a 0-cycle result bypass
// when the FIFO is empty.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ppu_apu_resp_buffer #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int FLAG_WIDTH = 5
) (
  input  wire logic                         clk_i,
  input  wire logic                         rst_ni,
  ppu_apu_resp_buffer_if.slave              bus,
  output logic                              overflow_o,
  output logic [$clog2(DEPTH+1)-1:0]        outstanding_o
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + FLAG_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Credit state
  logic [CNT_W-1:0]   out_cnt;
  // FIFO state
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;

  logic               can_issue;
  logic               unit_req;
  logic               issue;
  logic               retire;
  logic               fifo_empty;
  logic               fifo_full;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               drop;
  logic [ENTRY_W-1:0] head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign head       = mem[rd_ptr];

`ifdef PPU_RESP_BYPASS_EN
  // Unit result goes straight to the core while nothing older is queued.
  assign bypass = fifo_empty & bus.unit_rvalid_i;
`else
  assign bypass = 1'b0;
`endif

  // Request gating, result presentation and FIFO control strobes
  always_comb begin
    can_issue = (out_cnt < DEPTH_C);
    unit_req  = bus.core_req_i & can_issue;
    issue     = bus.unit_gnt_i & unit_req;

    bus.unit_req_o    = unit_req;
    bus.core_gnt_o    = issue;
    bus.core_rvalid_o = ~fifo_empty | bypass;
    bus.core_rdata_o  = head[DATA_WIDTH-1:0];
    bus.core_rflags_o = head[ENTRY_W-1:DATA_WIDTH];
    if (bypass) begin
      bus.core_rdata_o  = bus.unit_rdata_i;
      bus.core_rflags_o = bus.unit_rflags_i;
    end

    retire = bus.core_rvalid_o & bus.core_rready_i;
    // A bypassed result consumed in the same cycle never enters the FIFO.
    push   = bus.unit_rvalid_i & ~(bypass & bus.core_rready_i);
    pop    = retire & ~fifo_empty;
    wr_en  = push & (~fifo_full | pop);
    drop   = push & fifo_full & ~pop;
  end

  // Credit counter: one credit per operation from grant to core retire
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt <= '0;
    end else begin
      case ({issue, retire})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // FIFO pointers and occupancy; a full FIFO still accepts push with pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage, cleared on reset so the idle outputs read as zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= {bus.unit_rflags_i, bus.unit_rdata_i};
    end
  end

  // Sticky flag for a result that found no free slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (drop) begin
      overflow_o <= 1'b1;
    end
  end

  assign outstanding_o = out_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ppu_apu_resp_buffer.sv
// ============================================================================
// tb_ppu_apu_resp_buffer
// Scoreboard bench: stimulus plays core and unit, pushes expected results on
// grant; a negedge monitor checks handshake and result order against a
// transaction-level model of credits and buffered results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppu_apu_resp_buffer;
  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int FW    = 5;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef PPU_RESP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ppu_apu_resp_buffer_if #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW)) bus ();
  logic          overflow;
  logic [CW-1:0] outstanding;

  ppu_apu_resp_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FLAG_WIDTH(FW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .overflow_o    (overflow),
    .outstanding_o (outstanding)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and unit model state
  logic [DW+FW-1:0] exp_q [$];
  logic [DW+FW-1:0] pend_q [$];
  int               due_q [$];
  bit               mon_en = 1'b0;
  int               m_out = 0;
  int               m_stored = 0;
  int               cyc = 0;
  int               last_due = 0;
  bit               granted = 1'b0;
  logic [DW+FW-1:0] payload;

  // Monitor: model of credits held and results waiting for the core
  always @(negedge clk) begin
    bit ev, er, eg, ereq;
    logic [DW+FW-1:0] e;
    if (mon_en) begin
      ev   = (m_stored > 0) || (BYP && bus.unit_rvalid_i);
      ereq = bus.core_req_i && (m_out < DEPTH);
      eg   = ereq && bus.unit_gnt_i;
      chk("rvalid", bus.core_rvalid_o, ev);
      chk("unit_req", bus.unit_req_o, ereq);
      chk("core_gnt", bus.core_gnt_o, eg);
      chk("outstanding", outstanding, m_out);
      chk("overflow_quiet", overflow, 0);
      er = ev && bus.core_rready_i;
      if (er) begin
        if (exp_q.size() == 0) begin
          chk("result_expected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", bus.core_rdata_o, e[DW-1:0]);
          chk("rflags", bus.core_rflags_o, e[DW+FW-1:DW]);
        end
      end
      m_out    = m_out + int'(eg) - int'(er);
      m_stored = m_stored + int'(bus.unit_rvalid_i) - int'(er);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.core_req_i    = 1'b0;
    bus.core_rready_i = 1'b0;
    bus.unit_gnt_i    = 1'b0;
    bus.unit_rvalid_i = 1'b0;
    bus.unit_rdata_i  = '0;
    bus.unit_rflags_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    exp_q.delete();
    pend_q.delete();
    due_q.delete();
    granted  = 1'b0;
    m_out    = 0;
    m_stored = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One randomized cycle: unit delivers in order with 1..3 cycle latency
  task automatic stim_cycle(input bit allow_new, input int rready_pct);
    int due;
    step();
    cyc++;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      bus.unit_rvalid_i = 1'b1;
      {bus.unit_rflags_i, bus.unit_rdata_i} = pend_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      bus.unit_rvalid_i = 1'b0;
      bus.unit_rdata_i  = DW'($urandom);
      bus.unit_rflags_i = FW'($urandom);
    end
    if (granted) begin
      bus.core_req_i = 1'b0;
      granted = 1'b0;
    end
    if (allow_new && !bus.core_req_i && $urandom_range(0, 3) != 0) begin
      bus.core_req_i = 1'b1;
      payload = {FW'($urandom), DW'($urandom)};
    end
    bus.unit_gnt_i    = ($urandom_range(0, 3) != 0);
    bus.core_rready_i = ($urandom_range(1, 100) <= rready_pct);
    #1;
    if (bus.core_gnt_o) begin
      exp_q.push_back(payload);
      due = cyc + $urandom_range(1, 3);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_q.push_back(payload);
      due_q.push_back(due);
      granted = 1'b1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    // Reset state
    #1;
    chk("rst_rvalid", bus.core_rvalid_o, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rdata", bus.core_rdata_o, 0);
    chk("rst_rflags", bus.core_rflags_o, 0);
    chk("rst_unit_req", bus.unit_req_o, 0);
    do_reset();

    // Single operation, result 0x3F800000
    step();
    bus.core_req_i = 1'b1; bus.unit_gnt_i = 1'b1; bus.core_rready_i = 1'b1;
    #1;
    chk("one_unit_req", bus.unit_req_o, 1);
    chk("one_gnt", bus.core_gnt_o, 1);
    step();
    bus.core_req_i = 1'b0; bus.unit_gnt_i = 1'b0;
    bus.unit_rvalid_i = 1'b1; bus.unit_rdata_i = 32'h3F80_0000; bus.unit_rflags_i = '0;
    #1;
    chk("one_req_drop", bus.unit_req_o, 0);
    chk("one_rvalid_n", bus.core_rvalid_o, BYP);
    chk("one_rdata_n", bus.core_rdata_o, BYP ? 32'h3F80_0000 : 32'h0);
    chk("one_out_n", outstanding, 1);
    step();
    bus.unit_rvalid_i = 1'b0; bus.unit_rdata_i = '0;
    #1;
    chk("one_rvalid_n1", bus.core_rvalid_o, !BYP);
    chk("one_rdata_n1", bus.core_rdata_o, BYP ? 32'h0 : 32'h3F80_0000);
    chk("one_out_n1", outstanding, BYP ? 0 : 1);
    step();
    #1;
    chk("one_rvalid_end", bus.core_rvalid_o, 0);
    chk("one_out_end", outstanding, 0);
    do_reset();

    // Randomized traffic with varying core back-pressure
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int seg;
      seg = (i / 200) % 3;
      stim_cycle(1'b1, (seg == 0) ? 90 : (seg == 1) ? 50 : 10);
    end
    for (int k = 0; k < 300 && (exp_q.size() > 0 || bus.core_req_i); k++) begin
      stim_cycle(1'b0, 100);
    end
    step();
    drive_idle();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("drain_results", exp_q.size(), 0);
    chk("drain_out", outstanding, 0);
    do_reset();

    // Credit exhaustion, retire, and delayed re-issue
    step();
    bus.core_req_i = 1'b1; bus.unit_gnt_i = 1'b1;
    #1;
    chk("cr_gnt1", bus.core_gnt_o, 1);
    step();
    bus.unit_rvalid_i = 1'b1; bus.unit_rdata_i = 32'hA1; bus.unit_rflags_i = 5'h01;
    #1;
    chk("cr_gnt2", bus.core_gnt_o, 1);
    step();
    bus.unit_rdata_i = 32'hB2; bus.unit_rflags_i = 5'h02;
    #1;
    chk("cr_held_req", bus.unit_req_o, 0);
    chk("cr_held_gnt", bus.core_gnt_o, 0);
    chk("cr_full_out", outstanding, 2);
    chk("cr_head_a", bus.core_rdata_o, 32'hA1);
    step();
    bus.unit_rvalid_i = 1'b0; bus.core_rready_i = 1'b1;
    #1;
    chk("cr_retire_cycle_gnt", bus.core_gnt_o, 0);
    chk("cr_retire_data", bus.core_rdata_o, 32'hA1);
    chk("cr_retire_flags", bus.core_rflags_o, 5'h01);
    step();
    bus.core_rready_i = 1'b0;
    #1;
    chk("cr_next_gnt", bus.core_gnt_o, 1);
    chk("cr_head_b", bus.core_rdata_o, 32'hB2);
    chk("cr_out_1", outstanding, 1);
    step();
    bus.core_req_i = 1'b0;
    #1;
    chk("cr_out_2", outstanding, 2);
    chk("cr_one_entry", bus.core_rvalid_o, 1);
    // Asynchronous reset in mid-cycle
    rst_n = 1'b0;
    #1;
    chk("ar_rvalid", bus.core_rvalid_o, 0);
    chk("ar_outstanding", outstanding, 0);
    chk("ar_rdata", bus.core_rdata_o, 0);
    chk("ar_rflags", bus.core_rflags_o, 0);
    chk("ar_overflow", overflow, 0);
    do_reset();

    // Overflow from a result the credit scheme never allowed
    step();
    bus.core_req_i = 1'b1; bus.unit_gnt_i = 1'b1;
    step();
    bus.unit_rvalid_i = 1'b1; bus.unit_rdata_i = 32'h11; bus.unit_rflags_i = 5'h03;
    step();
    bus.core_req_i = 1'b0;
    bus.unit_rdata_i = 32'h22; bus.unit_rflags_i = 5'h04;
    step();
    bus.unit_rdata_i = 32'h33; bus.unit_rflags_i = 5'h05;
    #1;
    chk("ov_not_yet", overflow, 0);
    step();
    bus.unit_rvalid_i = 1'b0;
    #1;
    chk("ov_set", overflow, 1);
    chk("ov_head_kept", bus.core_rdata_o, 32'h11);
    step();
    bus.core_rready_i = 1'b1;
    #1;
    chk("ov_pop1", bus.core_rdata_o, 32'h11);
    step();
    #1;
    chk("ov_pop2", bus.core_rdata_o, 32'h22);
    chk("ov_pop2_flags", bus.core_rflags_o, 5'h04);
    step();
    bus.core_rready_i = 1'b0;
    #1;
    chk("ov_empty", bus.core_rvalid_o, 0);
    chk("ov_sticky", overflow, 1);
    chk("ov_out", outstanding, 0);
    do_reset();
    #1;
    chk("ov_cleared", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
